// File: rtl/audio_rom_player_if.sv
// Bus bundle between the playback sequencer, the single-port sample ROM
// and the codec-side valid/ready sample stream.
interface audio_rom_player_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] rom_address;
   logic                  rom_chipselect;
   logic                  rom_clken;
   logic [DATA_WIDTH-1:0] rom_readdata;
   logic [DATA_WIDTH-1:0] sample_data;
   logic                  sample_valid;
   logic                  sample_ready;

   modport master (
      output rom_address,
      output rom_chipselect,
      output rom_clken,
      output sample_data,
      output sample_valid,
      input  rom_readdata,
      input  sample_ready
   );

   modport slave (
      input  rom_address,
      input  rom_chipselect,
      input  rom_clken,
      input  sample_data,
      input  sample_valid,
      output rom_readdata,
      output sample_ready
   );
endinterface

// File: rtl/audio_rom_player.sv
// Playback sequencer for the audio sample ROM. A free-running sample-rate
// tick (active only while busy) paces one ROM read per sample period; each
// word is latched and offered downstream on a valid/ready stream. Ticks that
// arrive while one is still outstanding are counted as underruns.
module audio_rom_player #(
   parameter int ADDR_WIDTH  = 17,
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_SAMPLES = 120127,
   parameter int TICK_DIV    = 1042
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  loop_en,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] play_pos,
   output logic [15:0]           underrun_cnt,
   audio_rom_player_if.master    bus
);

   localparam int                    CNT_WIDTH = $clog2(TICK_DIV);
   localparam logic [CNT_WIDTH-1:0]  TICK_LAST = CNT_WIDTH'(TICK_DIV - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_SAMPLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_FETCH,
      S_LATCH,
      S_PRESENT
   } state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] tick_cnt;
   logic                 tick_pending;
   logic                 tick;

   assign tick = busy && (tick_cnt == TICK_LAST);

   // Sequencer: tick pacing, underrun accounting and the fetch/present FSM with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state              <= S_IDLE;
         tick_cnt           <= '0;
         tick_pending       <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
         play_pos           <= '0;
         underrun_cnt       <= '0;
         bus.rom_address    <= '0;
         bus.rom_chipselect <= 1'b0;
         bus.rom_clken      <= 1'b0;
         bus.sample_data    <= '0;
         bus.sample_valid   <= 1'b0;
      end else begin
         done               <= 1'b0;
         bus.rom_chipselect <= 1'b0;
         bus.rom_clken      <= 1'b0;

         if (busy) begin
            if (tick) begin
               tick_cnt <= '0;
            end else begin
               tick_cnt <= tick_cnt + CNT_WIDTH'(1);
            end
         end

         if (tick) begin
            tick_pending <= 1'b1;
            if (tick_pending && (underrun_cnt != 16'hFFFF)) begin
               underrun_cnt <= underrun_cnt + 16'd1;
            end
         end

         if (stop) begin
            state            <= S_IDLE;
            busy             <= 1'b0;
            play_pos         <= '0;
            tick_cnt         <= '0;
            tick_pending     <= 1'b0;
            bus.sample_valid <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state        <= S_WAIT;
                     busy         <= 1'b1;
                     play_pos     <= '0;
                     tick_cnt     <= '0;
                     tick_pending <= 1'b0;
                  end
               end

               S_WAIT: begin
                  if (tick_pending) begin
                     state              <= S_FETCH;
                     tick_pending       <= tick;
                     bus.rom_address    <= play_pos;
                     bus.rom_chipselect <= 1'b1;
                     bus.rom_clken      <= 1'b1;
                  end
               end

               S_FETCH: begin
                  state <= S_LATCH;
               end

               S_LATCH: begin
                  state            <= S_PRESENT;
                  bus.sample_data  <= DATA_WIDTH'(bus.rom_readdata);
                  bus.sample_valid <= 1'b1;
               end

               S_PRESENT: begin
                  if (bus.sample_valid && bus.sample_ready) begin
                     bus.sample_valid <= 1'b0;
                     if (play_pos != LAST_ADDR) begin
                        play_pos <= play_pos + ADDR_WIDTH'(1);
                        state    <= S_WAIT;
                     end else if (loop_en) begin
                        play_pos <= '0;
                        state    <= S_WAIT;
                     end else begin
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        play_pos     <= '0;
                        tick_cnt     <= '0;
                        tick_pending <= 1'b0;
                        state        <= S_IDLE;
                     end
                  end
               end

               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
